target_slew: RTL and testbench



---
 rtl/slew_pkg.sv | 43 ++++
 rtl/stable_filter.sv | 70 +++++++
 rtl/target_slew.sv | 153 +++++++++++++++
 tb/tb_target_slew.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slew_pkg.sv
// Shared types and helpers for the target slew limiter.
//   slew_state_e : ramp direction (IDLE / UP / DOWN)
//   DEF_*        : default widths used by target_slew
//   SAT_W        : width of the sat_step datapath; callers zero-extend into it,
//                  and keep WIDTH < SAT_W so at least one headroom bit exists
//   sat_step()   : one clamped ramp step toward goal
package slew_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } slew_state_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STEP_W = 16;
  localparam int DEF_DIV_W  = 16;
  localparam int SAT_W      = 64;

  // Moves cur by step toward goal without crossing it. Operands are
  // zero-extended values narrower than SAT_W, so the up-sum cannot wrap.
  // The down path keeps an explicit borrow bit so step > cur clamps to goal
  // instead of wrapping to a huge value.
  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] cur,
    input logic [SAT_W-1:0] goal,
    input logic [SAT_W-1:0] step,
    input logic             up
  );
    logic [SAT_W-1:0] sum;
    logic [SAT_W:0]   diff;
    sum  = cur + step;
    diff = {1'b0, cur} - {1'b0, step};
    if (up) begin
      return (sum > goal) ? goal : sum;
    end
    if (diff[SAT_W] || (diff[SAT_W-1:0] < goal)) begin
      return goal;
    end
    return diff[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/stable_filter.sv
// Input conditioning for target_slew: 2-flop synchroniser on the raw target,
// a stability counter, and the goal register.
//   clk, rst_n : block clock, async active-low reset
//   target_in  : raw target, asynchronous to clk and may glitch
//   goal       : last accepted target
//   goal_load  : high in the cycle goal takes a new (different) value;
//                goal changes on the following clock edge
// A value is accepted once the synchronised copy has been unchanged for
// STABLE_CYC cycles, the cycle it first appears counting as the first one.
// This gives 2+STABLE_CYC cycles from a clean input change to goal update.
module stable_filter
  import slew_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               STABLE_CYC = 1024,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target_in,
  output logic [WIDTH-1:0] goal,
  output logic             goal_load
);

  localparam int             CW      = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             changed;
  logic             reached;

  assign changed = (sync != prev);

  always_comb begin
    cnt_next = cnt;
    if (changed) begin
      cnt_next = CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // First arrival at the saturation value; holding there does not reload.
  assign reached   = (cnt_next == CNT_MAX) && (changed || (cnt != CNT_MAX));
  // Reloading the value goal already has is not reported as a change.
  assign goal_load = reached && (sync != goal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
      cnt  <= '0;
      goal <= RESET_VAL;
    end else begin
      meta <= target_in;
      sync <= meta;
      prev <= sync;
      cnt  <= cnt_next;
      if (goal_load) begin
        goal <= sync;
      end
    end
  end

endmodule

// File: rtl/target_slew.sv
// Slew-rate limiter between switch decoding and the DSP stage. The raw target
// is filtered by stable_filter into goal; target_out then ramps toward goal in
// steps of eff_step on each prescaler tick.
//   clk, rst_n  : block clock, async active-low reset
//   enable      : 1 = ramp advances, 0 = output frozen and prescaler held at 0
//   target_in   : raw target (async, may glitch)
//   step        : increment per tick, 0 behaves as 1
//   tick_div    : tick period minus 1
//   target_out  : rate-limited target
//   busy        : registered, high while target_out != goal
//   done        : one-cycle pulse after a ramp step lands on goal
// Build option TARGET_SLEW_BYPASS_EN adds input `bypass`: while high,
// target_out follows goal directly, no ramp, no busy, no done.
//
// state | meaning
// IDLE  | target_out == goal
// UP    | target_out <  goal
// DOWN  | target_out >  goal
module target_slew
  import slew_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               STEP_W     = DEF_STEP_W,
  parameter int               DIV_W      = DEF_DIV_W,
  parameter int               STABLE_CYC = 1024,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef TARGET_SLEW_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              enable,
  input  logic [WIDTH-1:0]  target_in,
  input  logic [STEP_W-1:0] step,
  input  logic [DIV_W-1:0]  tick_div,
  output logic [WIDTH-1:0]  target_out,
  output logic              busy,
  output logic              done
);

  localparam int OUT_PAD  = SAT_W - WIDTH;
  localparam int STEP_PAD = SAT_W - STEP_W;

  logic [WIDTH-1:0]  goal;
  logic              goal_load;
  logic              hold_off;
  logic              run;
  logic              tick;
  logic [DIV_W-1:0]  pre_cnt;
  slew_state_e       state;
  slew_state_e       state_next;
  logic [STEP_W-1:0] eff_step;
  logic [SAT_W-1:0]  sat_res;
  logic [WIDTH-1:0]  ramp_val;
  logic              moving;
  logic              step_hit;
  logic              hit_q;
  logic              unused_sat_hi;

`ifdef TARGET_SLEW_BYPASS_EN
  assign hold_off = bypass;
`else
  assign hold_off = 1'b0;
`endif

  stable_filter #(
    .WIDTH      (WIDTH),
    .STABLE_CYC (STABLE_CYC),
    .RESET_VAL  (RESET_VAL)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .target_in (target_in),
    .goal      (goal),
    .goal_load (goal_load)
  );

  // Prescaler. >= rather than == so a tick_div lowered below the running
  // count still ticks at the next compare instead of wrapping the counter.
  assign run  = enable && !hold_off;
  assign tick = run && (pre_cnt >= tick_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!run || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Direction from the registered values of this cycle; it also steers the
  // arithmetic below, so a goal that jumps past target_out reverses the ramp
  // immediately instead of clamping onto the far side.
  always_comb begin
    state_next = IDLE;
    if (hold_off) begin
      state_next = IDLE;
    end else if (target_out < goal) begin
      state_next = UP;
    end else if (target_out > goal) begin
      state_next = DOWN;
    end
  end

  always_comb begin
    busy = (state != IDLE) && !hold_off;
  end

  assign eff_step = (step == '0) ? STEP_W'(1) : step;
  assign sat_res  = sat_step({{OUT_PAD{1'b0}}, target_out},
                             {{OUT_PAD{1'b0}}, goal},
                             {{STEP_PAD{1'b0}}, eff_step},
                             state_next == UP);
  assign ramp_val      = sat_res[WIDTH-1:0];
  assign unused_sat_hi = |sat_res[SAT_W-1:WIDTH];

  assign moving   = tick && (state_next != IDLE);
  // A step that lands on the goal being replaced this cycle is not an arrival.
  assign step_hit = moving && (ramp_val == goal) && !goal_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_out <= RESET_VAL;
    end else if (hold_off) begin
      target_out <= goal;
    end else if (moving) begin
      target_out <= ramp_val;
    end
  end

  // done lines up with busy falling: both land one cycle after the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      hit_q <= step_hit;
      done  <= hit_q && !hold_off;
    end
  end

endmodule

// File: tb/tb_target_slew.sv
module tb_target_slew;

  localparam int W  = 32;
  localparam int SW = 16;
  localparam int DW = 16;
  localparam int SC = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [W-1:0]  target_in;
  logic [SW-1:0] step;
  logic [DW-1:0] tick_div;
  logic [W-1:0]  target_out;
  logic          busy;
  logic          done;

  target_slew #(
    .WIDTH      (W),
    .STEP_W     (SW),
    .DIV_W      (DW),
    .STABLE_CYC (SC),
    .RESET_VAL  ('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .target_in  (target_in),
    .step       (step),
    .tick_div   (tick_div),
    .target_out (target_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: goal is the newest synchronised sample that closes a run
  // of SC equal samples; target_out moves toward goal by the effective step on
  // each tick, clamped at goal.
  longint unsigned m_out, m_goal;
  int              m_phase;
  bit              m_busy, m_done, m_hit;
  logic [W-1:0]    hist[$];
  logic [W-1:0]    peak;
  int              done_seen;

  task automatic model_reset();
    m_out   = 0;
    m_goal  = 0;
    m_phase = 0;
    m_busy  = 0;
    m_done  = 0;
    m_hit   = 0;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
  endtask

  task automatic model_edge();
    longint unsigned g_new, o_new, eff;
    longint          d;
    bit              tk, hit, same;
    int              e;
    g_new = m_goal;
    hist.push_back(target_in);
    e = hist.size() - 3;
    if (e >= SC - 1) begin
      same = 1;
      for (int j = e - SC + 1; j <= e; j++) if (hist[j] != hist[e]) same = 0;
      if (same) g_new = 64'(hist[e]);
    end
    if (hist.size() > 4 * SC) void'(hist.pop_front());
    tk = (enable === 1'b1) && (m_phase == int'(tick_div));
    o_new = m_out;
    if (tk && m_out != m_goal) begin
      eff = (step == '0) ? 64'd1 : 64'(step);
      if (m_out < m_goal) begin
        o_new = m_out + eff;
        if (o_new > m_goal) o_new = m_goal;
      end else begin
        d = longint'(m_out) - longint'(eff);
        o_new = (d < longint'(m_goal)) ? m_goal : longint'(d);
      end
    end
    hit     = tk && (m_out != m_goal) && (o_new == m_goal) && (g_new == m_goal);
    m_done  = m_hit;
    m_hit   = hit;
    m_busy  = (m_out != m_goal);
    m_phase = (!(enable === 1'b1) || tk) ? 0 : m_phase + 1;
    m_out   = o_new;
    m_goal  = g_new;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("target_out", target_out, m_out);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (target_out > peak) peak = target_out;
    if (done) done_seen++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out", target_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic settle(input int budget);
    int n;
    repeat (SC + 3) cycle();
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    chk("settle_idle", busy, 0);
  endtask

  initial begin
    logic [W-1:0] fr;
    int           n;
    int           dcnt;
    logic [63:0]  exp_v;

    // Reset, then first ramp 0 -> 1000 in steps of 100 every cycle.
    rst_n     = 1'b0;
    enable    = 1'b1;
    target_in = 1000;
    step      = 100;
    tick_div  = 0;
    peak      = '0;
    done_seen = 0;
    model_reset();
    @(negedge clk);
    chk("reset_out", target_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    dcnt  = 0;
    for (int i = 1; i <= 18; i++) begin
      cycle();
      exp_v = (i <= 6) ? 0 : ((i >= 16) ? 1000 : 64'((i - 6) * 100));
      chk("ramp1", target_out, exp_v);
      if (done) dcnt++;
    end
    chk("ramp1_done_cnt", dcnt, 1);
    chk("ramp1_busy_end", busy, 0);

    // Up clamp: 1000 -> 950 -> 1000 with step 100 never reaches 1050.
    target_in = 950;
    settle(100);
    chk("down_950", target_out, 950);
    peak = '0;
    target_in = 1000;
    settle(100);
    chk("upclamp_final", target_out, 1000);
    chk("upclamp_peak", peak, 1000);

    // Underflow guard: 50 -> 0 with step 100 in one tick.
    target_in = 50;
    settle(100);
    chk("down_50", target_out, 50);
    target_in = 0;
    settle(100);
    chk("underflow_final", target_out, 0);

    // Glitch rejection: 5/7 toggling every 2 cycles is never accepted.
    for (int i = 0; i < 50; i++) begin
      target_in = ((i / 2) % 2 == 1) ? 7 : 5;
      cycle();
    end
    target_in = 0;
    chk("glitch_out", target_out, 0);
    chk("glitch_busy", busy, 0);

    // Mid-ramp reversal, freeze, resume.
    enable   = 1'b0;
    tick_div = 3;
    step     = 100;
    target_in = 800;
    cycle();
    enable = 1'b1;
    n = 0;
    while (m_out < 400 && n < 200) begin
      cycle();
      n++;
    end
    chk("rev_reach400", target_out, 400);
    target_in = 200;
    repeat (10) cycle();
    enable = 1'b0;
    fr = W'(m_out);
    repeat (20) begin
      cycle();
      chk("freeze", target_out, fr);
    end
    enable = 1'b1;
    settle(400);
    chk("rev_final", target_out, 200);

    // Async reset mid-ramp, then recover.
    target_in = 3000;
    repeat (SC + 8) cycle();
    do_reset();
    settle(400);
    chk("after_reset_final", target_out, 3000);

    // Randomised segments.
    for (int seg = 0; seg < 80; seg++) begin
      int len;
      bit glitch;
      if ($urandom_range(0, 9) == 0) do_reset();
      case ($urandom_range(0, 3))
        0: target_in = W'($urandom_range(0, 4000));
        1: target_in = W'($urandom());
        2: target_in = '0;
        default: target_in = 32'hFFFF_FFFF - W'($urandom_range(0, 3000));
      endcase
      step = ($urandom_range(0, 3) == 0) ? SW'($urandom()) : SW'($urandom_range(0, 300));
      if ($urandom_range(0, 4) == 0) begin
        enable   = 1'b0;
        tick_div = DW'($urandom_range(0, 3));
      end else begin
        enable = 1'b1;
      end
      len    = $urandom_range(2, 40);
      glitch = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < len; i++) begin
        if (glitch && (i % 3 == 0)) target_in = target_in ^ 32'h1;
        cycle();
      end
    end

    // Top clamp: goal 0xFFFF_FFFF with step 0xFFFF never overflows.
    do_reset();
    enable    = 1'b1;
    tick_div  = 0;
    step      = 16'hFFFF;
    target_in = 32'hFFFF_FFFF;
    settle(70000);
    chk("top_clamp_final", target_out, 64'h0000_0000_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
